// File: rtl/adder_rr_scheduler_pkg.sv
// Shared types for the round-robin adder scheduler.
// State encoding, default width and owner-index sizing helper.
package adder_sched_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adder_rr_scheduler_if.sv
// Requester-side bundle: operand request and response handshakes.
// master = requester fabric, slave = scheduler.
interface adder_rr_scheduler_if
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = WIDTH_DEF
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [NUM_REQ-1:0]       resp_ready;
  logic [WIDTH-1:0]         resp_sum;
  logic                     resp_carry;
  logic                     resp_err;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_sum,
    input  resp_carry,
    input  resp_err
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_sum,
    output resp_carry,
    output resp_err
  );

endinterface

// File: rtl/adder_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request
// after ptr, wrapping around.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/adder_rr_scheduler.sv
// Shares one 2-cycle adder among NUM_REQ requesters, round-robin.
// Define ADDER_SCHED_TIMEOUT_EN to add the WAIT-state watchdog.
module adder_rr_scheduler
  import adder_sched_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int WIDTH       = WIDTH_DEF,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  adder_rr_scheduler_if.slave bus,
  output logic                busy,
  output logic [WIDTH-1:0]    add_value_a,
  output logic [WIDTH-1:0]    add_value_b,
  output logic                add_data_val,
  input  logic [WIDTH-1:0]    add_sum_result,
  input  logic                add_sum_carry,
  input  logic                add_data_ready
);

  localparam int IW = idx_w(NUM_REQ);

  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYC must be at least 1");
  end

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      owner;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               dv_q;
  logic [NUM_REQ-1:0] resp_v;
  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gidx;
  logic               any;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req (bus.req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  // Ready is gated by reset so nothing is offered while held in reset.
  assign bus.req_ready  = (state == IDLE && reset_n) ? gnt : '0;
  assign bus.resp_valid = resp_v;
  assign bus.resp_sum   = sum_q;
  assign bus.resp_carry = carry_q;
  assign busy           = (state != IDLE);
  assign add_value_a    = op_a;
  assign add_value_b    = op_b;
  assign add_data_val   = dv_q;

`ifdef ADDER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] wcnt;
  logic          err_q;
  assign bus.resp_err = err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ptr     <= IW'(NUM_REQ - 1);
      owner   <= '0;
      op_a    <= '0;
      op_b    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      dv_q    <= 1'b0;
      resp_v  <= '0;
`ifdef ADDER_SCHED_TIMEOUT_EN
      wcnt    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            op_a  <= bus.req_a[gidx*WIDTH +: WIDTH];
            op_b  <= bus.req_b[gidx*WIDTH +: WIDTH];
            owner <= gidx;
            ptr   <= gidx;
            dv_q  <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: begin
          dv_q  <= 1'b0;
          state <= WAIT;
`ifdef ADDER_SCHED_TIMEOUT_EN
          wcnt  <= '0;
`endif
        end
        WAIT: begin
          if (add_data_ready) begin
            sum_q   <= add_sum_result;
            carry_q <= add_sum_carry;
            resp_v  <= NUM_REQ'(1) << owner;
            state   <= RESP;
`ifdef ADDER_SCHED_TIMEOUT_EN
            err_q   <= 1'b0;
          end else if (wcnt == TW'(TIMEOUT_CYC - 1)) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            err_q   <= 1'b1;
            resp_v  <= NUM_REQ'(1) << owner;
            state   <= RESP;
          end else begin
            wcnt    <= wcnt + 1'b1;
`endif
          end
        end
        RESP: begin
          if (bus.resp_ready[owner]) begin
            resp_v <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a 2-cycle adder model.
// Build with ADDER_SCHED_TIMEOUT_EN to exercise the watchdog path.
module tb_adder_rr_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       busy;
  logic [7:0] add_value_a;
  logic [7:0] add_value_b;
  logic       add_data_val;
  logic [7:0] add_sum_result;
  logic       add_sum_carry;
  logic       add_data_ready;

  logic       p1;
  logic       rdy;
  logic [7:0] ta;
  logic [7:0] tbo;
  logic       stub_dead;
  logic       late_pulse;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         lat;
  logic [3:0] g;

  always #5 clk = ~clk;

  adder_rr_scheduler_if #(.NUM_REQ(4), .WIDTH(8)) bus ();

  adder_rr_scheduler #(
    .NUM_REQ     (4),
    .WIDTH       (8),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus.slave),
    .busy           (busy),
    .add_value_a    (add_value_a),
    .add_value_b    (add_value_b),
    .add_data_val   (add_data_val),
    .add_sum_result (add_sum_result),
    .add_sum_carry  (add_sum_carry),
    .add_data_ready (add_data_ready)
  );

  // Adder model: Data_val sampled, Data_ready two cycles later.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1             <= 1'b0;
      rdy            <= 1'b0;
      ta             <= '0;
      tbo            <= '0;
      add_sum_result <= '0;
      add_sum_carry  <= 1'b0;
    end else begin
      p1  <= add_data_val;
      rdy <= p1 && !stub_dead;
      if (add_data_val) begin
        ta  <= add_value_a;
        tbo <= add_value_b;
      end
      if (p1) begin
        {add_sum_carry, add_sum_result} <= {1'b0, ta} + {1'b0, tbo};
      end
    end
  end

  assign add_data_ready = rdy | late_pulse;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  task automatic ack(input int idx);
    bus.resp_ready[idx] = 1'b1;
    tick();
    bus.resp_ready = '0;
  endtask

  // lat counts cycles from the accept cycle (accept cycle = 0).
  task automatic run_op(input int idx, input logic [7:0] a,
                        input logic [7:0] b, output int l,
                        output logic [3:0] gr);
    bus.req_a[idx*8 +: 8] = a;
    bus.req_b[idx*8 +: 8] = b;
    bus.req_valid[idx]    = 1'b1;
    #1;
    for (int w = 0; w < 20 && bus.req_ready == 4'b0; w++) tick();
    gr = bus.req_ready;
    l  = 99;
    if (gr == 4'b0) begin
      bus.req_valid[idx] = 1'b0;
      return;
    end
    tick();
    bus.req_valid[idx] = 1'b0;
    l = 1;
    while (bus.resp_valid == 4'b0 && l < 40) begin
      tick();
      l++;
    end
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    bus.req_valid  = 4'hF;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = '0;
    stub_dead      = 1'b0;
    late_pulse     = 1'b0;
    tick();
    n_cmp++;
    if ({busy, add_data_val, add_value_a, add_value_b} !== 18'b0) begin
      n_bad++;
      $display("FAIL reset_core: got %0b/%0b/%0d/%0d want 0",
               busy, add_data_val, add_value_a, add_value_b);
    end
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid} !== 8'b0) begin
      n_bad++;
      $display("FAIL reset_hs: rdy=%b rv=%b want 0",
               bus.req_ready, bus.resp_valid);
    end
    n_cmp++;
    if ({bus.resp_sum, bus.resp_carry, bus.resp_err} !== 10'b0) begin
      n_bad++;
      $display("FAIL reset_resp: sum=%0d c=%b e=%b want 0",
               bus.resp_sum, bus.resp_carry, bus.resp_err);
    end
    bus.req_valid = '0;
    reset_n       = 1'b1;
    tick();
  endtask

  task automatic test_single();
    run_op(0, 8'd5, 8'd3, lat, g);
    n_cmp++;
    if (g !== 4'b0001) begin
      n_bad++;
      $display("FAIL t1_grant: got %b want 0001", g);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL t1_latency: got %0d want 4", lat);
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_sum, bus.resp_carry} !== {4'b0001, 8'd8, 1'b0}) begin
      n_bad++;
      $display("FAIL t1_resp: rv=%b sum=%0d c=%b want 0001/8/0",
               bus.resp_valid, bus.resp_sum, bus.resp_carry);
    end
    ack(0);
    n_cmp++;
    if ({busy, bus.resp_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL t1_exit: busy=%b rv=%b want 0/0000", busy, bus.resp_valid);
    end
  endtask

  task automatic test_wrap();
    run_op(1, 8'd255, 8'd1, lat, g);
    n_cmp++;
    if ({g, bus.resp_valid} !== 8'b0010_0010) begin
      n_bad++;
      $display("FAIL t2_owner1: g=%b rv=%b want 0010/0010", g, bus.resp_valid);
    end
    n_cmp++;
    if ({bus.resp_sum, bus.resp_carry} !== {8'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL t2_wrap: sum=%0d c=%b want 0/1",
               bus.resp_sum, bus.resp_carry);
    end
    ack(1);
    run_op(2, 8'd200, 8'd55, lat, g);
    n_cmp++;
    if ({g, bus.resp_valid} !== 8'b0100_0100) begin
      n_bad++;
      $display("FAIL t2_owner2: g=%b rv=%b want 0100/0100", g, bus.resp_valid);
    end
    n_cmp++;
    if ({bus.resp_sum, bus.resp_carry} !== {8'd255, 1'b0}) begin
      n_bad++;
      $display("FAIL t2_max: sum=%0d c=%b want 255/0",
               bus.resp_sum, bus.resp_carry);
    end
    ack(2);
  endtask

  task automatic test_round_robin();
    int exp_o [5] = '{0, 1, 2, 3, 0};
    int w;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_a[i*8 +: 8] = 8'(10 * (i + 1));
      bus.req_b[i*8 +: 8] = 8'(i + 1);
    end
    bus.req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_cmp++;
      if (bus.req_ready !== 4'(1 << exp_o[k])) begin
        n_bad++;
        $display("FAIL t3_grant%0d: got %b want %b",
                 k, bus.req_ready, 4'(1 << exp_o[k]));
      end
      tick();
      w = 0;
      while (bus.resp_valid == 4'b0 && w < 40) begin
        tick();
        w++;
      end
      n_cmp++;
      if ({bus.resp_valid, bus.resp_sum} !==
          {4'(1 << exp_o[k]), 8'(11 * (exp_o[k] + 1))}) begin
        n_bad++;
        $display("FAIL t3_resp%0d: rv=%b sum=%0d want %b/%0d", k,
                 bus.resp_valid, bus.resp_sum,
                 4'(1 << exp_o[k]), 11 * (exp_o[k] + 1));
      end
      ack(exp_o[k]);
    end
    bus.req_valid = '0;
    tick();
  endtask

  task automatic test_resp_hold();
    run_op(2, 8'd100, 8'd100, lat, g);
    bus.req_a[7:0] = 8'd1;
    bus.req_b[7:0] = 8'd1;
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 4'b1011;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if ({bus.req_ready, bus.resp_valid, bus.resp_sum, bus.resp_carry} !==
          {4'b0000, 4'b0100, 8'd200, 1'b0}) begin
        n_bad++;
        $display("FAIL t4_hold%0d: rdy=%b rv=%b sum=%0d c=%b want 0000/0100/200/0",
                 c, bus.req_ready, bus.resp_valid, bus.resp_sum, bus.resp_carry);
      end
    end
    bus.resp_ready = 4'b0100;
    tick();
    bus.resp_ready = '0;
    n_cmp++;
    if ({busy, bus.resp_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL t4_exit: busy=%b rv=%b want 0/0000", busy, bus.resp_valid);
    end
    #1;
    n_cmp++;
    if (bus.req_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL t4_idle_rdy: got %b want 0001", bus.req_ready);
    end
    bus.req_valid = '0;
    tick();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL t4_drop: busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_op();
    bus.req_a[7:0] = 8'd7;
    bus.req_b[7:0] = 8'd8;
    bus.req_valid  = 4'b0001;
    #1;
    tick();
    bus.req_valid = '0;
    n_cmp++;
    if ({add_data_val, add_value_a, add_value_b} !== {1'b1, 8'd7, 8'd8}) begin
      n_bad++;
      $display("FAIL t5_issue: dv=%b a=%0d b=%0d want 1/7/8",
               add_data_val, add_value_a, add_value_b);
    end
    tick();
    n_cmp++;
    if ({busy, add_data_val, add_value_a} !== {1'b1, 1'b0, 8'd7}) begin
      n_bad++;
      $display("FAIL t5_wait: busy=%b dv=%b a=%0d want 1/0/7",
               busy, add_data_val, add_value_a);
    end
    bus.req_valid = 4'b0010;
    reset_n       = 1'b0;
    #1;
    n_cmp++;
    if ({busy, add_data_val, add_value_a, add_value_b, bus.req_ready,
         bus.resp_valid, bus.resp_sum, bus.resp_carry, bus.resp_err} !== 36'b0) begin
      n_bad++;
      $display("FAIL t5_abort: busy=%b dv=%b a=%0d rdy=%b rv=%b want all 0",
               busy, add_data_val, add_value_a, bus.req_ready, bus.resp_valid);
    end
    tick();
    bus.req_valid = '0;
    reset_n       = 1'b1;
    tick();
    run_op(0, 8'd10, 8'd20, lat, g);
    n_cmp++;
    if ({g, bus.resp_valid, bus.resp_sum} !== {4'b0001, 4'b0001, 8'd30}) begin
      n_bad++;
      $display("FAIL t5_fresh: g=%b rv=%b sum=%0d want 0001/0001/30",
               g, bus.resp_valid, bus.resp_sum);
    end
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL t5_latency: got %0d want 4", lat);
    end
    ack(0);
  endtask

  task automatic test_timeout();
    stub_dead = 1'b1;
`ifdef ADDER_SCHED_TIMEOUT_EN
    run_op(0, 8'd1, 8'd2, lat, g);
    n_cmp++;
    if (lat !== 18) begin
      n_bad++;
      $display("FAIL t6_tmo_lat: got %0d want 18", lat);
    end
    n_cmp++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_sum, bus.resp_carry} !==
        {4'b0001, 1'b1, 8'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL t6_tmo_resp: rv=%b e=%b sum=%0d c=%b want 0001/1/0/0",
               bus.resp_valid, bus.resp_err, bus.resp_sum, bus.resp_carry);
    end
    late_pulse = 1'b1;
    tick();
    late_pulse = 1'b0;
    n_cmp++;
    if ({bus.resp_valid, bus.resp_err, bus.resp_sum} !== {4'b0001, 1'b1, 8'd0}) begin
      n_bad++;
      $display("FAIL t6_late: rv=%b e=%b sum=%0d want 0001/1/0",
               bus.resp_valid, bus.resp_err, bus.resp_sum);
    end
    ack(0);
    late_pulse = 1'b1;
    tick();
    late_pulse = 1'b0;
    n_cmp++;
    if ({busy, bus.resp_valid} !== 5'b0) begin
      n_bad++;
      $display("FAIL t6_idle_pulse: busy=%b rv=%b want 0/0000", busy, bus.resp_valid);
    end
    stub_dead = 1'b0;
    run_op(3, 8'd4, 8'd5, lat, g);
    n_cmp++;
    if ({g, lat, bus.resp_err, bus.resp_sum} !== {4'b1000, 32'd4, 1'b0, 8'd9}) begin
      n_bad++;
      $display("FAIL t6_normal: g=%b lat=%0d e=%b sum=%0d want 1000/4/0/9",
               g, lat, bus.resp_err, bus.resp_sum);
    end
    ack(3);
`else
    run_op(0, 8'd1, 8'd2, lat, g);
    n_cmp++;
    if ({busy, bus.resp_valid, bus.resp_err} !== {1'b1, 4'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL t6_stall: busy=%b rv=%b e=%b want 1/0000/0",
               busy, bus.resp_valid, bus.resp_err);
    end
    stub_dead = 1'b0;
    do_reset();
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_resp_hold();
    test_reset_mid_op();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
